// File: rtl/float_to_fixed_81.sv
// IEEE-754 single to signed Q24.8 converter.
// Input capture, then unpack / shift / sign-saturate stages.
module float_to_fixed_81 (
  input  logic        clk81,
  input  logic        reset_81,
  input  logic        valid_in_81,
  input  logic [31:0] a81,
  output logic        valid_out_81,
  output logic [31:0] result_81,
  output logic        overflow_81,
  output logic        nan_81,
  output logic        inexact_81
);

  logic        v0;
  logic [31:0] a0;

  logic        v1;
  logic        s1;
  logic        zero1;
  logic        den1;
  logic        nan1;
  logic        inf1;
  logic [23:0] mag1;
  logic [9:0]  k1;

  logic        v2;
  logic        s2;
  logic        nan2;
  logic        ovf2;
  logic        inx2;
  logic [31:0] mag2;

  logic [7:0]  e0;
  logic [22:0] m0;
  logic [9:0]  nr;
  logic [31:0] sh;
  logic        ovf_c;
  logic        inx_c;
  logic [31:0] res_c;
  logic        ov_c;
  logic        ix_c;

  assign e0 = a0[30:23];
  assign m0 = a0[22:0];

  always_ff @(posedge clk81) begin
    if (reset_81) begin
      v0 <= 1'b0;
      a0 <= '0;
    end else begin
      v0 <= valid_in_81;
      a0 <= a81;
    end
  end

  always_ff @(posedge clk81) begin
    if (reset_81) begin
      v1    <= 1'b0;
      s1    <= 1'b0;
      zero1 <= 1'b0;
      den1  <= 1'b0;
      nan1  <= 1'b0;
      inf1  <= 1'b0;
      mag1  <= '0;
      k1    <= '0;
    end else begin
      v1    <= v0;
      s1    <= a0[31];
      zero1 <= (e0 == 8'd0);
      den1  <= (e0 == 8'd0) && (m0 != 23'd0);
      nan1  <= (e0 == 8'hFF) && (m0 != 23'd0);
      inf1  <= (e0 == 8'hFF) && (m0 == 23'd0);
      mag1  <= {1'b1, m0};
      k1    <= {2'b00, e0} - 10'd142;
    end
  end

  // k1 is two's complement; bit 9 set means a right shift.
  always_comb begin
    nr    = 10'd0 - k1;
    sh    = '0;
    ovf_c = 1'b0;
    inx_c = 1'b0;
    if (nan1) begin
      sh = '0;
    end else if (inf1) begin
      ovf_c = 1'b1;
    end else if (zero1) begin
      inx_c = den1;
    end else if (!k1[9]) begin
      if (k1 >= 10'd9) ovf_c = 1'b1;
      else sh = {8'd0, mag1} << k1[3:0];
    end else if (nr >= 10'd24) begin
      inx_c = 1'b1;
    end else begin
      sh    = {8'd0, mag1} >> nr[4:0];
      inx_c = |(mag1 & ((24'd1 << nr[4:0]) - 24'd1));
    end
  end

  always_ff @(posedge clk81) begin
    if (reset_81) begin
      v2   <= 1'b0;
      s2   <= 1'b0;
      nan2 <= 1'b0;
      ovf2 <= 1'b0;
      inx2 <= 1'b0;
      mag2 <= '0;
    end else begin
      v2   <= v1;
      s2   <= s1;
      nan2 <= nan1;
      ovf2 <= ovf_c;
      inx2 <= inx_c;
      mag2 <= sh;
    end
  end

  // Negative side reaches one step further: -2^31 is representable.
  always_comb begin
    res_c = '0;
    ov_c  = 1'b0;
    ix_c  = 1'b0;
    if (nan2) begin
      res_c = '0;
    end else if (ovf2) begin
      res_c = s2 ? 32'h8000_0000 : 32'h7FFF_FFFF;
      ov_c  = 1'b1;
    end else if (!s2 && mag2[31]) begin
      res_c = 32'h7FFF_FFFF;
      ov_c  = 1'b1;
    end else if (s2 && (mag2 > 32'h8000_0000)) begin
      res_c = 32'h8000_0000;
      ov_c  = 1'b1;
    end else begin
      res_c = s2 ? (32'd0 - mag2) : mag2;
      ix_c  = inx2;
    end
  end

  always_ff @(posedge clk81) begin
    if (reset_81) begin
      valid_out_81 <= 1'b0;
      result_81    <= '0;
      overflow_81  <= 1'b0;
      nan_81       <= 1'b0;
      inexact_81   <= 1'b0;
    end else begin
      valid_out_81 <= v2;
      if (v2) begin
        result_81   <= res_c;
        overflow_81 <= ov_c;
        nan_81      <= nan2;
        inexact_81  <= ix_c;
      end
    end
  end

endmodule

// File: tb/tb_float_to_fixed_81.sv
// Bench for float_to_fixed_81: real-arithmetic model,
// per-cycle latency/value compare, directed and random stimulus.
module tb_float_to_fixed_81;

  logic        clk81 = 1'b0;
  logic        reset_81;
  logic        valid_in_81;
  logic [31:0] a81;
  logic        valid_out_81;
  logic [31:0] result_81;
  logic        overflow_81;
  logic        nan_81;
  logic        inexact_81;

  int total = 0;
  int bad = 0;

  float_to_fixed_81 dut (
    .clk81(clk81),
    .reset_81(reset_81),
    .valid_in_81(valid_in_81),
    .a81(a81),
    .valid_out_81(valid_out_81),
    .result_81(result_81),
    .overflow_81(overflow_81),
    .nan_81(nan_81),
    .inexact_81(inexact_81)
  );

  always #5 clk81 = ~clk81;

  // Returns {nan, overflow, inexact, result}.
  function automatic logic [34:0] model(input logic [31:0] a);
    logic s;
    int e;
    real x;
    real t;
    longint li;
    logic [31:0] r;
    logic nf;
    logic of;
    logic ix;
    s  = a[31];
    e  = int'(a[30:23]);
    r  = '0;
    nf = 1'b0;
    of = 1'b0;
    ix = 1'b0;
    if (e == 255) begin
      if (a[22:0] != 0) nf = 1'b1;
      else begin
        of = 1'b1;
        r  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else if (e == 0) begin
      ix = (a[22:0] != 0);
    end else begin
      // value * 256 = 1.m * 2^(e-127+8) = {1,m} * 2^(e-142)
      x = real'(int'(a[22:0]) + 8388608);
      if (e >= 142) for (int i = 0; i < e - 142; i++) x = x * 2.0;
      else for (int i = 0; i < 142 - e; i++) x = x / 2.0;
      t  = $floor(x);
      ix = (x != t);
      if ((!s && t >= 2147483648.0) || (s && t > 2147483648.0)) begin
        of = 1'b1;
        ix = 1'b0;
        r  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        li = longint'(t);
        if (s) li = -li;
        r = li[31:0];
      end
    end
    return {nf, of, ix, r};
  endfunction

  typedef struct {
    int          due;
    logic [34:0] exp;
  } item_t;

  item_t       q[$];
  int          edges = 0;
  logic        started = 1'b0;
  logic [34:0] held = '0;

  always @(posedge clk81) begin
    item_t it;
    edges   = edges + 1;
    started = 1'b1;
    if (reset_81) begin
      q.delete();
      held = '0;
    end else if (valid_in_81) begin
      it.due = edges + 3;
      it.exp = model(a81);
      q.push_back(it);
    end
  end

  always @(negedge clk81) begin
    logic [34:0] got;
    if (started) begin
      got = {nan_81, overflow_81, inexact_81, result_81};
      total = total + 1;
      if (q.size() > 0 && q[0].due == edges) begin
        held = q[0].exp;
        void'(q.pop_front());
        if (valid_out_81 !== 1'b1 || got !== held) begin
          bad = bad + 1;
          $display("FAIL out edge=%0d got v=%b nof=%h want v=1 nof=%h",
                   edges, valid_out_81, got, held);
        end
      end else if (valid_out_81 !== 1'b0 || got !== held) begin
        bad = bad + 1;
        $display("FAIL idle edge=%0d got v=%b nof=%h want v=0 nof=%h",
                 edges, valid_out_81, got, held);
      end
    end
  end

  task automatic send(input logic [31:0] a);
    @(negedge clk81);
    valid_in_81 = 1'b1;
    a81 = a;
  endtask

  task automatic bubble();
    @(negedge clk81);
    valid_in_81 = 1'b0;
    a81 = $urandom;
  endtask

  logic [31:0] pin_a[12] = '{
    32'h42C40000, 32'hC2DC4000, 32'h43858000, 32'h3F800001,
    32'h4AFFFFFF, 32'h4B000000, 32'hCB000000, 32'hCB000001,
    32'h7F800000, 32'h7FC00000, 32'h00000001, 32'h3A83126F
  };
  logic [34:0] pin_e[12] = '{
    {3'b000, 32'h00006200}, {3'b000, 32'hFFFF91E0},
    {3'b000, 32'h00010B00}, {3'b001, 32'h00000100},
    {3'b000, 32'h7FFFFF80}, {3'b010, 32'h7FFFFFFF},
    {3'b000, 32'h80000000}, {3'b010, 32'h80000000},
    {3'b010, 32'h7FFFFFFF}, {3'b100, 32'h00000000},
    {3'b001, 32'h00000000}, {3'b001, 32'h00000000}
  };

  logic [31:0] dir_a[10] = '{
    32'hC2DC4000, 32'h43858000, 32'h3F800001, 32'h4AFFFFFF,
    32'h4B000000, 32'hCB000000, 32'hCB000001, 32'h7F800000,
    32'hFF800000, 32'h7FC00000
  };

  initial begin
    logic [34:0] m;
    logic [31:0] ra;
    reset_81 = 1'b1;
    valid_in_81 = 1'b0;
    a81 = '0;

    for (int i = 0; i < 12; i++) begin
      m = model(pin_a[i]);
      total = total + 1;
      if (m !== pin_e[i]) begin
        bad = bad + 1;
        $display("FAIL pin%0d a=%h got %h want %h", i, pin_a[i], m, pin_e[i]);
      end
    end

    @(negedge clk81);
    @(negedge clk81);
    valid_in_81 = 1'b1;
    a81 = 32'h3F800000;
    @(negedge clk81);
    reset_81 = 1'b0;
    a81 = 32'h42C40000;
    bubble();
    repeat (5) bubble();

    foreach (dir_a[i]) send(dir_a[i]);
    send(32'hFFFFFFFF);
    bubble();
    send(32'h80000000);
    send(32'h00000001);
    bubble();
    bubble();
    send(32'h3A83126F);
    send(32'h807FFFFF);
    repeat (5) bubble();

    send(32'h42C40000);
    send(32'h43858000);
    @(negedge clk81);
    valid_in_81 = 1'b0;
    reset_81 = 1'b1;
    @(negedge clk81);
    reset_81 = 1'b0;
    repeat (6) bubble();
    send(32'hC2DC4000);
    repeat (4) bubble();

    for (int n = 0; n < 10000; n++) begin
      while ($urandom_range(99, 0) < 30) bubble();
      if ($urandom_range(19, 0) == 0) ra = $urandom;
      else begin
        ra = $urandom;
        ra[30:23] = 8'($urandom_range(160, 110));
      end
      send(ra);
    end
    repeat (6) bubble();

    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
